// File: rtl/ysyx22041405_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ysyx22041405_mem_arbiter_pkg
// Shared definitions for the IFU/LSU memory arbiter:
//   - state_e      : arbiter FSM encoding (IDLE / REQ / RSP)
//   - OWN_IFU/LSU  : owner codes, also used as round-robin grant codes
//   - req_bundle_w : width of a packed request {addr, wdata, wen, wmask}
// ---------------------------------------------------------------------------
package ysyx22041405_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam int DEF_WIDTH = 32;

  // Packed request = addr + wdata + wen + wmask.
  function automatic int req_bundle_w(input int width);
    return 2 * width + width / 8 + 1;
  endfunction

  localparam int REQ_BUNDLE_W = req_bundle_w(DEF_WIDTH);

endpackage

// File: rtl/ysyx22041405_rr_arb2.sv
// ---------------------------------------------------------------------------
// ysyx22041405_rr_arb2
// Two-input round-robin picker. A lone requester always wins; on a tie the
// input that did not win last time is chosen.
//   i_req[1:0]   : request lines (bit 0 = IFU, bit 1 = LSU)
//   i_last_grant : index of the previous winner
//   o_valid      : at least one request present
//   o_grant      : index of the chosen requester (meaningful when o_valid)
// ---------------------------------------------------------------------------
module ysyx22041405_rr_arb2
  import ysyx22041405_mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_valid,
  output logic       o_grant
);

  always_comb begin
    o_valid = |i_req;
    o_grant = OWN_IFU;
    case (i_req)
      2'b01:   o_grant = OWN_IFU;
      2'b10:   o_grant = OWN_LSU;
      2'b11:   o_grant = ~i_last_grant;
      default: o_grant = OWN_IFU;
    endcase
  end

endmodule

// File: rtl/ysyx22041405_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx22041405_mem_arbiter
// Shares one memory port between the IFU (read-only) and the LSU. One
// transaction in flight, round-robin on ties, and a response timeout that
// completes a hung transaction with err = 1 and rdata = 0.
// Ports:
//   i_clk, i_rst_n                : clock, asynchronous active-low reset
//   i/o_ifu_req_*, i/o_ifu_rsp_*  : IFU request / response channels
//   i/o_lsu_req_*, i/o_lsu_rsp_*  : LSU request / response channels
//   o/i_mem_req_*, o/i_mem_rsp_*  : slave request / response channels
// All routing is combinational from the registered state and owner.
// ---------------------------------------------------------------------------
module ysyx22041405_mem_arbiter
  import ysyx22041405_mem_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  // IFU
  input  logic                 i_ifu_req_valid,
  output logic                 o_ifu_req_ready,
  input  logic [WIDTH-1:0]     i_ifu_req_addr,
  output logic                 o_ifu_rsp_valid,
  input  logic                 i_ifu_rsp_ready,
  output logic [WIDTH-1:0]     o_ifu_rsp_rdata,
  output logic                 o_ifu_rsp_err,
  // LSU
  input  logic                 i_lsu_req_valid,
  output logic                 o_lsu_req_ready,
  input  logic [WIDTH-1:0]     i_lsu_req_addr,
  input  logic [WIDTH-1:0]     i_lsu_req_wdata,
  input  logic                 i_lsu_req_wen,
  input  logic [WIDTH/8-1:0]   i_lsu_req_wmask,
  output logic                 o_lsu_rsp_valid,
  input  logic                 i_lsu_rsp_ready,
  output logic [WIDTH-1:0]     o_lsu_rsp_rdata,
  output logic                 o_lsu_rsp_err,
  // Slave
  output logic                 o_mem_req_valid,
  input  logic                 i_mem_req_ready,
  output logic [WIDTH-1:0]     o_mem_req_addr,
  output logic [WIDTH-1:0]     o_mem_req_wdata,
  output logic                 o_mem_req_wen,
  output logic [WIDTH/8-1:0]   o_mem_req_wmask,
  input  logic                 i_mem_rsp_valid,
  output logic                 o_mem_rsp_ready,
  input  logic [WIDTH-1:0]     i_mem_rsp_rdata
);

  localparam int MASK_W = WIDTH / 8;
  localparam int BUN_W  = req_bundle_w(WIDTH);
  // At least one bit so TIMEOUT = 0 still elaborates cleanly.
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e             r_state, w_state_next;
  logic               r_owner, w_owner_next;
  logic               r_last_grant, w_last_grant_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;

  logic               w_arb_valid, w_arb_grant;
  logic               w_own_req_valid, w_own_rsp_ready;
  logic               w_forced;
  logic [BUN_W-1:0]   w_ifu_bundle, w_lsu_bundle, w_sel_bundle;
  logic               w_rsp_valid, w_rsp_err;
  logic [WIDTH-1:0]   w_rsp_rdata;

  ysyx22041405_rr_arb2 u_rr_arb2 (
    .i_req        ({i_lsu_req_valid, i_ifu_req_valid}),
    .i_last_grant (r_last_grant),
    .o_valid      (w_arb_valid),
    .o_grant      (w_arb_grant)
  );

  // The IFU never writes: its bundle carries zero wdata/wen/wmask.
  assign w_ifu_bundle = {i_ifu_req_addr, {WIDTH{1'b0}}, 1'b0, {MASK_W{1'b0}}};
  assign w_lsu_bundle = {i_lsu_req_addr, i_lsu_req_wdata, i_lsu_req_wen, i_lsu_req_wmask};
  assign w_sel_bundle = (r_owner == OWN_LSU) ? w_lsu_bundle : w_ifu_bundle;

  assign w_own_req_valid = (r_owner == OWN_LSU) ? i_lsu_req_valid : i_ifu_req_valid;
  assign w_own_rsp_ready = (r_owner == OWN_LSU) ? i_lsu_rsp_ready : i_ifu_rsp_ready;

  // The counter saturates at TIMEOUT, so "forced" is simply counter == TIMEOUT.
  assign w_forced = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_IFU;
      r_last_grant <= OWN_IFU;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_last_grant <= w_last_grant_next;
      r_cnt        <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_last_grant_next = r_last_grant;
    w_cnt_next        = r_cnt;

    o_ifu_req_ready = 1'b0;
    o_lsu_req_ready = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_req_addr  = '0;
    o_mem_req_wdata = '0;
    o_mem_req_wen   = 1'b0;
    o_mem_req_wmask = '0;
    o_mem_rsp_ready = 1'b0;
    o_ifu_rsp_valid = 1'b0;
    o_ifu_rsp_rdata = '0;
    o_ifu_rsp_err   = 1'b0;
    o_lsu_rsp_valid = 1'b0;
    o_lsu_rsp_rdata = '0;
    o_lsu_rsp_err   = 1'b0;
    w_rsp_valid     = 1'b0;
    w_rsp_rdata     = '0;
    w_rsp_err       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_state_next = ST_REQ;
          w_owner_next = w_arb_grant;
        end
      end

      ST_REQ: begin
        o_mem_req_valid = w_own_req_valid;
        {o_mem_req_addr, o_mem_req_wdata, o_mem_req_wen, o_mem_req_wmask} = w_sel_bundle;
        if (r_owner == OWN_LSU) o_lsu_req_ready = i_mem_req_ready;
        else                    o_ifu_req_ready = i_mem_req_ready;

        if (w_own_req_valid && i_mem_req_ready) begin
          w_state_next      = ST_RSP;
          w_cnt_next        = '0;
          w_last_grant_next = r_owner;
        end else if (!w_own_req_valid) begin
          // Owner withdrew its request: abandon without touching last_grant.
          w_state_next = ST_IDLE;
        end
      end

      ST_RSP: begin
        if (w_forced) begin
          // Slave is decoupled here, so a late response is never accepted.
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
          if (w_own_rsp_ready) w_state_next = ST_IDLE;
        end else begin
          w_rsp_valid     = i_mem_rsp_valid;
          w_rsp_rdata     = i_mem_rsp_rdata;
          o_mem_rsp_ready = w_own_rsp_ready;
          if (i_mem_rsp_valid && w_own_rsp_ready) begin
            w_state_next = ST_IDLE;
          end else if (!i_mem_rsp_valid && (TIMEOUT != 0)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end

        if (r_owner == OWN_LSU) begin
          o_lsu_rsp_valid = w_rsp_valid;
          o_lsu_rsp_rdata = w_rsp_rdata;
          o_lsu_rsp_err   = w_rsp_err;
        end else begin
          o_ifu_rsp_valid = w_rsp_valid;
          o_ifu_rsp_rdata = w_rsp_rdata;
          o_ifu_rsp_err   = w_rsp_err;
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx22041405_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx22041405_mem_arbiter
// Directed scenarios for the IFU/LSU memory arbiter (TIMEOUT = 4).
// Inputs change 1 ns after the rising edge; outputs are compared 1 ns later.
// ---------------------------------------------------------------------------
module tb_ysyx22041405_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rsp_rdata;
  logic        ifu_rsp_err;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic        lsu_req_wen;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_rsp_rdata;
  logic        lsu_rsp_err;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_req_wen;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx22041405_mem_arbiter #(.WIDTH(32), .TIMEOUT(4)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_ifu_req_valid (ifu_req_valid),
    .o_ifu_req_ready (ifu_req_ready),
    .i_ifu_req_addr  (ifu_req_addr),
    .o_ifu_rsp_valid (ifu_rsp_valid),
    .i_ifu_rsp_ready (ifu_rsp_ready),
    .o_ifu_rsp_rdata (ifu_rsp_rdata),
    .o_ifu_rsp_err   (ifu_rsp_err),
    .i_lsu_req_valid (lsu_req_valid),
    .o_lsu_req_ready (lsu_req_ready),
    .i_lsu_req_addr  (lsu_req_addr),
    .i_lsu_req_wdata (lsu_req_wdata),
    .i_lsu_req_wen   (lsu_req_wen),
    .i_lsu_req_wmask (lsu_req_wmask),
    .o_lsu_rsp_valid (lsu_rsp_valid),
    .i_lsu_rsp_ready (lsu_rsp_ready),
    .o_lsu_rsp_rdata (lsu_rsp_rdata),
    .o_lsu_rsp_err   (lsu_rsp_err),
    .o_mem_req_valid (mem_req_valid),
    .i_mem_req_ready (mem_req_ready),
    .o_mem_req_addr  (mem_req_addr),
    .o_mem_req_wdata (mem_req_wdata),
    .o_mem_req_wen   (mem_req_wen),
    .o_mem_req_wmask (mem_req_wmask),
    .i_mem_rsp_valid (mem_rsp_valid),
    .o_mem_rsp_ready (mem_rsp_ready),
    .i_mem_rsp_rdata (mem_rsp_rdata)
  );

  // All handshake/err outputs and all data outputs, for "everything idle" checks.
  wire [8:0]   ctl_w  = {ifu_req_ready, ifu_rsp_valid, ifu_rsp_err,
                         lsu_req_ready, lsu_rsp_valid, lsu_rsp_err,
                         mem_req_valid, mem_req_wen, mem_rsp_ready};
  wire [131:0] data_w = {mem_req_addr, mem_req_wdata, mem_req_wmask,
                         ifu_rsp_rdata, lsu_rsp_rdata};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_req_valid = 0; ifu_req_addr = '0; ifu_rsp_ready = 0;
    lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wdata = '0;
    lsu_req_wen = 0; lsu_req_wmask = '0; lsu_rsp_ready = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    ifu_req_valid = 1; lsu_req_valid = 1; mem_req_ready = 1;
    mem_rsp_valid = 1; mem_rsp_rdata = 32'hFFFF_FFFF;
    ifu_rsp_ready = 1; lsu_rsp_ready = 1;
    tick(); tick();
    #1;
    n_checks++;
    if (ctl_w !== 9'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl_w, 9'b0);
    end
    n_checks++;
    if (data_w !== 132'b0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", data_w);
    end
    clear_inputs();
    rst_n = 1;
    tick();
    $display("reset: held two cycles, released");
  endtask

  task automatic test_ifu_only();
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
    mem_req_ready = 1; ifu_rsp_ready = 1;
    #1;
    n_checks++;
    if (ctl_w !== 9'b0) begin
      n_fail++; $display("FAIL ifu_idle: got %b expected %b", ctl_w, 9'b0);
    end
    tick();
    #1;
    n_checks++;
    if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_req_wen} !== 4'b1010) begin
      n_fail++; $display("FAIL ifu_req_hs: got %b expected 1010",
                         {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_req_wen});
    end
    n_checks++;
    if ({mem_req_addr, mem_req_wdata, mem_req_wmask} !== {32'h8000_0000, 32'h0, 4'h0}) begin
      n_fail++; $display("FAIL ifu_req_fields: got %h %h %h expected 80000000 0 0",
                         mem_req_addr, mem_req_wdata, mem_req_wmask);
    end
    tick();
    ifu_req_valid = 0;
    mem_rsp_valid = 1; mem_rsp_rdata = 32'h0010_0073;
    #1;
    n_checks++;
    if ({ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready, lsu_rsp_valid, mem_req_valid} !== 5'b10100) begin
      n_fail++; $display("FAIL ifu_rsp_hs: got %b expected 10100",
                         {ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready, lsu_rsp_valid, mem_req_valid});
    end
    n_checks++;
    if (ifu_rsp_rdata !== 32'h0010_0073) begin
      n_fail++; $display("FAIL ifu_rdata: got %h expected 00100073", ifu_rsp_rdata);
    end
    tick();
    mem_rsp_valid = 0;
    #1;
    n_checks++;
    if (ctl_w !== 9'b0) begin
      n_fail++; $display("FAIL ifu_back_idle: got %b expected %b", ctl_w, 9'b0);
    end
    $display("ifu_only: fetch 80000000 -> %h err=%b", 32'h0010_0073, ifu_rsp_err);
  endtask

  task automatic test_tie();
    logic       exp_lsu;
    logic [31:0] exp_addr;
    rst_n = 0;
    tick();
    rst_n = 1;
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0100;
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_0200; lsu_req_wen = 0;
    mem_req_ready = 1; mem_rsp_valid = 1;
    ifu_rsp_ready = 1; lsu_rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      exp_lsu  = (k % 2 == 0);
      exp_addr = exp_lsu ? 32'h8000_0200 : 32'h8000_0100;
      mem_rsp_rdata = 32'h1111_0000 + k;
      #1;
      n_checks++;
      if ({ifu_req_ready, lsu_req_ready, mem_req_valid} !== 3'b000) begin
        n_fail++; $display("FAIL tie_idle[%0d]: got %b expected 000", k,
                           {ifu_req_ready, lsu_req_ready, mem_req_valid});
      end
      tick();
      #1;
      n_checks++;
      if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_req_addr} !==
          {~exp_lsu, exp_lsu, 1'b1, exp_addr}) begin
        n_fail++; $display("FAIL tie_grant[%0d]: got rdy=%b%b addr=%h expected rdy=%b%b addr=%h",
                           k, ifu_req_ready, lsu_req_ready, mem_req_addr,
                           ~exp_lsu, exp_lsu, exp_addr);
      end
      tick();
      #1;
      n_checks++;
      if ({ifu_rsp_valid, lsu_rsp_valid} !== {~exp_lsu, exp_lsu} ||
          (exp_lsu ? lsu_rsp_rdata : ifu_rsp_rdata) !== 32'h1111_0000 + k) begin
        n_fail++; $display("FAIL tie_rsp[%0d]: got v=%b%b expected v=%b%b rdata %h", k,
                           ifu_rsp_valid, lsu_rsp_valid, ~exp_lsu, exp_lsu, 32'h1111_0000 + k);
      end
      $display("tie[%0d]: granted %s", k, exp_lsu ? "LSU" : "IFU");
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_lsu_store();
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_1000; lsu_req_wdata = 32'hDEAD_BEEF;
    lsu_req_wmask = 4'b0011; lsu_req_wen = 1;
    mem_req_ready = 1; lsu_rsp_ready = 1; ifu_rsp_ready = 1;
    tick();
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_2000;
    #1;
    n_checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wen, mem_req_wmask} !==
        {1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 1'b1, 4'b0011}) begin
      n_fail++; $display("FAIL store_fields: got v=%b a=%h d=%h w=%b m=%b expected 1 80001000 deadbeef 1 0011",
                         mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wen, mem_req_wmask);
    end
    n_checks++;
    if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL store_ready: got %b expected 10", {lsu_req_ready, ifu_req_ready});
    end
    tick();
    lsu_req_valid = 0;
    mem_rsp_valid = 1; mem_rsp_rdata = 32'h0;
    #1;
    n_checks++;
    if ({lsu_rsp_valid, lsu_rsp_err, ifu_req_ready, ifu_rsp_valid} !== 4'b1000) begin
      n_fail++; $display("FAIL store_rsp: got %b expected 1000",
                         {lsu_rsp_valid, lsu_rsp_err, ifu_req_ready, ifu_rsp_valid});
    end
    $display("lsu_store: addr 80001000 data deadbeef mask 0011");
    tick();
    mem_rsp_valid = 0;
    #1;
    n_checks++;
    if ({ifu_req_ready, mem_req_valid} !== 2'b00) begin
      n_fail++; $display("FAIL store_gap_idle: got %b expected 00", {ifu_req_ready, mem_req_valid});
    end
    tick();
    #1;
    n_checks++;
    if ({ifu_req_ready, lsu_req_ready, mem_req_addr, mem_req_wen, mem_req_wmask} !==
        {2'b10, 32'h8000_2000, 1'b0, 4'b0000}) begin
      n_fail++; $display("FAIL pending_ifu: got rdy=%b%b a=%h w=%b m=%b expected 10 80002000 0 0000",
                         ifu_req_ready, lsu_req_ready, mem_req_addr, mem_req_wen, mem_req_wmask);
    end
    tick();
    ifu_req_valid = 0;
    mem_rsp_valid = 1; mem_rsp_rdata = 32'h0000_0013;
    #1;
    n_checks++;
    if ({ifu_rsp_valid, ifu_rsp_rdata} !== {1'b1, 32'h0000_0013}) begin
      n_fail++; $display("FAIL pending_ifu_rsp: got %b %h expected 1 00000013", ifu_rsp_valid, ifu_rsp_rdata);
    end
    $display("lsu_store: pending IFU fetch 80002000 served next");
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout();
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0080; mem_req_ready = 1;
    tick();
    #1;
    n_checks++;
    if (ifu_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL to_req_ready: got %b expected 1", ifu_req_ready);
    end
    tick();
    ifu_req_valid = 0; mem_req_ready = 0;
    for (int r = 1; r <= 4; r++) begin
      #1;
      n_checks++;
      if ({ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready} !== 3'b000) begin
        n_fail++; $display("FAIL to_wait[%0d]: got %b expected 000", r,
                           {ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready});
      end
      tick();
    end
    #1;
    n_checks++;
    if ({ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready, ifu_rsp_rdata} !== {3'b110, 32'h0}) begin
      n_fail++; $display("FAIL to_forced: got %b rdata=%h expected 110 rdata=0",
                         {ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready}, ifu_rsp_rdata);
    end
    tick();
    mem_rsp_valid = 1; mem_rsp_rdata = 32'h1234_5678;
    #1;
    n_checks++;
    if ({ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready, ifu_rsp_rdata} !== {3'b110, 32'h0}) begin
      n_fail++; $display("FAIL to_late_drop: got %b rdata=%h expected 110 rdata=0",
                         {ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready}, ifu_rsp_rdata);
    end
    ifu_rsp_ready = 1;
    tick();
    mem_rsp_valid = 0; ifu_rsp_ready = 0;
    #1;
    n_checks++;
    if ({ifu_rsp_valid, ifu_rsp_err, mem_req_valid} !== 3'b000) begin
      n_fail++; $display("FAIL to_back_idle: got %b expected 000",
                         {ifu_rsp_valid, ifu_rsp_err, mem_req_valid});
    end
    $display("timeout: fetch 80000080 completed with err after 4 RSP cycles");
    clear_inputs();
  endtask

  task automatic test_backpressure();
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0040;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if ({ifu_req_ready, mem_req_valid, mem_req_addr} !== {2'b01, 32'h8000_0040}) begin
        n_fail++; $display("FAIL bp_req_hold[%0d]: got %b%b %h expected 01 80000040", c,
                           ifu_req_ready, mem_req_valid, mem_req_addr);
      end
      tick();
    end
    mem_req_ready = 1;
    #1;
    n_checks++;
    if (ifu_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_req_accept: got %b expected 1", ifu_req_ready);
    end
    tick();
    ifu_req_valid = 0; mem_req_ready = 0;
    mem_rsp_valid = 1; mem_rsp_rdata = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({ifu_rsp_valid, mem_rsp_ready, ifu_rsp_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
        n_fail++; $display("FAIL bp_rsp_hold[%0d]: got %b%b %h expected 10 cafef00d", c,
                           ifu_rsp_valid, mem_rsp_ready, ifu_rsp_rdata);
      end
      tick();
    end
    ifu_rsp_ready = 1;
    #1;
    n_checks++;
    if ({ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready} !== 3'b101) begin
      n_fail++; $display("FAIL bp_rsp_accept: got %b expected 101",
                         {ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready});
    end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (ctl_w !== 9'b0) begin
      n_fail++; $display("FAIL bp_back_idle: got %b expected %b", ctl_w, 9'b0);
    end
    $display("backpressure: fetch 80000040 -> cafef00d after 5 req stalls, 3 rsp stalls");
  endtask

  task automatic test_reset_mid();
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_3000;
    mem_req_ready = 1; lsu_rsp_ready = 1;
    tick();
    tick();
    lsu_req_valid = 0;
    #1;
    n_checks++;
    if (mem_rsp_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: got %b expected 1", mem_rsp_ready);
    end
    rst_n = 0;
    #1;
    n_checks++;
    if (ctl_w !== 9'b0) begin
      n_fail++; $display("FAIL rst_mid_ctl: got %b expected %b", ctl_w, 9'b0);
    end
    n_checks++;
    if (data_w !== 132'b0) begin
      n_fail++; $display("FAIL rst_mid_data: got %h expected 0", data_w);
    end
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_4000;
    lsu_req_valid = 1;
    tick();
    rst_n = 1;
    #1;
    n_checks++;
    if (ctl_w !== 9'b0) begin
      n_fail++; $display("FAIL rst_release_idle: got %b expected %b", ctl_w, 9'b0);
    end
    tick();
    #1;
    n_checks++;
    if ({ifu_req_ready, lsu_req_ready, mem_req_addr} !== {2'b01, 32'h8000_3000}) begin
      n_fail++; $display("FAIL rst_first_tie: got %b%b %h expected 01 80003000",
                         ifu_req_ready, lsu_req_ready, mem_req_addr);
    end
    $display("reset_mid: LSU transaction aborted in RSP, first tie after reset to LSU");
    clear_inputs();
    tick();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_ifu_only();
    test_tie();
    test_lsu_store();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
